if_id_pipe_stage: RTL and testbench
===================================

// Module: if_id_pipe_stage
// PURPOSE
//  Parametrised fetch->decode pipeline stage replacing the plain IF/ID register.
//  Carries instruction, PC and PC+4 with valid/ready handshake, flush and a 2-entry skid buffer.
//  in_ready is fully registered, so decode-side stalls never form a combinational path back into fetch.
//  Sits between the fetch unit (PC mux, imem) and the decode unit (regfile, imm gen, hazard unit).
// PARAMETERS
//  XLEN       32             width of instr, PC and PC+4 payload fields
//  NOP_INSTR  32'h0000_0013  bubble encoding (addi x0,x0,0); used only with IF_ID_NOP_BUBBLE_EN
// PORTS
//  clk       in   1     clock, all state updates on rising edge
//  rst       in   1     asynchronous reset, active-low
//  flush     in   1     synchronous flush from branch/jump resolution
//  in_valid  in   1     fetch presents a valid instruction
//  in_ready  out  1     stage can accept (registered)
//  instrF    in   XLEN  fetched instruction
//  PCF       in   XLEN  fetch PC
//  PCPlus4F  in   XLEN  fetch PC+4
//  out_valid out  1     instrD/PCD/PCPlus4D hold a valid instruction
//  out_ready in   1     decode consumes this cycle (0 = stall)
//  instrD    out  XLEN  decode-stage instruction
//  PCD       out  XLEN  decode-stage PC
//  PCPlus4D  out  XLEN  decode-stage PC+4
// BEHAVIOUR
//  - Reset (rst=0, async): out_valid=0, in_ready=1, instrD/PCD/PCPlus4D=0, skid cleared, state EMPTY.
//  - Accept = in_valid & in_ready. Issue = out_valid & out_ready.
//  - States: EMPTY (no entry), FULL (main slot valid), SKID (main and skid slots valid).
//  - EMPTY: accept -> main<=input, FULL. No accept -> stay.
//  - FULL:
//    - issue & accept -> main<=input, stay FULL.
//    - issue & !accept -> EMPTY.
//    - !issue & accept -> skid<=input, SKID, in_ready<=0.
//    - neither -> hold.
//  - SKID: issue -> main<=skid, FULL, in_ready<=1. !issue -> hold all.
//  - in_ready = 0 only in SKID. out_valid = 1 in FULL and SKID.
//  - Latency: 1 cycle input->output when unstalled. Throughput: 1 instr/cycle.
//  - Entries leave strictly in order. No entry is dropped or duplicated, except on flush.
//  - flush has the highest priority:
//    - next state EMPTY, out_valid=0, in_ready=1.
//    - main and skid payloads cleared to 0.
//    - An input offered in the flush cycle is discarded.
//    - An issue in the flush cycle is still counted by decode (entry already consumed).
//  - Payload registers change only on load/flush/reset; outputs are stable while out_valid & !out_ready.
//  - Reset mid-stream: immediate clear. First accept is possible on the first clk edge after rst rises.
// CONFIGURATION
//  - Macro IF_ID_NOP_BUBBLE_EN defined:
//    - reset and flush load instrD with NOP_INSTR instead of 0.
//    - while out_valid=0, instrD reads NOP_INSTR, so legacy decode that ignores out_valid sees a bubble.
//  - Undefined: bubble value is 32'h0 (current codebase behaviour).
//  - PCD/PCPlus4D clear to 0 in both cases.
// STRUCTURE
//  - Package riscv_pipe_pkg: XLEN default, NOP_INSTR constant, typedef if_id_payload_t {instr,pc,pc4},
//    state enum {EMPTY,FULL,SKID}.
//  - Sub-module pipe_payload_slot (async active-low reset, load, clear, bubble value) instantiated twice: main, skid.
//  - Top contains the FSM and in_ready register only.
// TESTING
//  - Reset: rst=0 mid-stream -> out_valid=0, in_ready=1, instrD=0 (NOP 0x00000013 with macro) without a clk edge.
//  - Streaming: out_ready=1, feed PCF=0x0,0x4,0x8 back-to-back -> PCD=0x0,0x4,0x8 on consecutive cycles, 1-cycle latency.
//  - Stall fill: out_ready=0, send PC 0x10, 0x14 -> state SKID, in_ready=0.
//    Then out_ready=1 -> issues 0x10 then 0x14, in order, none lost.
//  - Flush in SKID: flush=1 with in_valid PC 0x20 -> next cycle out_valid=0, in_ready=1, PC 0x20 never appears.
//  - Flush+stall+accept same cycle: flush wins, state EMPTY. Next accept of PC 0x40 is issued alone.
//  - Random valid/ready soak: 10k cycles -> scoreboard shows in-order, lossless between flushes. in_ready never combinationally depends on out_ready.

Source files
------------

// File: rtl/riscv_pipe_pkg.sv
// Shared types and constants for the fetch->decode pipeline stage.
package riscv_pipe_pkg;

    localparam int          XLEN      = 32;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;  // addi x0,x0,0

    typedef struct packed {
        logic [XLEN-1:0] instr;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] pc4;
    } if_id_payload_t;

    // EMPTY: nothing held, FULL: main slot valid, SKID: main and skid slots valid
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        FULL  = 2'd1,
        SKID  = 2'd2
    } if_id_state_e;

endpackage

// File: rtl/pipe_payload_slot.sv
// One payload register of the IF/ID stage. Reset and clear both load the
// bubble value; clear wins over load so a flush always empties the slot.
module pipe_payload_slot #(
    parameter int           W      = 96,
    parameter logic [W-1:0] BUBBLE = '0
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         load_i,
    input  logic         clear_i,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);

    logic [W-1:0] slot_q;

    // Payload changes only on reset, clear or load; otherwise it holds.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)      slot_q <= BUBBLE;
        else if (clear_i) slot_q <= BUBBLE;
        else if (load_i)  slot_q <= d_i;
    end

    assign q_o = slot_q;

endmodule

// File: rtl/if_id_pipe_stage.sv
// Fetch->decode pipeline stage with valid/ready handshake, flush and a
// 2-entry (main + skid) buffer. in_ready comes straight from a flop so a
// decode stall never reaches fetch combinationally.
// Optional feature macro: IF_ID_NOP_BUBBLE_EN (instrD shows NOP_INSTR as bubble).
module if_id_pipe_stage
    import riscv_pipe_pkg::*;
#(
    parameter int              XLEN      = riscv_pipe_pkg::XLEN,
    parameter logic [XLEN-1:0] NOP_INSTR = XLEN'(riscv_pipe_pkg::NOP_INSTR)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] instrF,
    input  logic [XLEN-1:0] PCF,
    input  logic [XLEN-1:0] PCPlus4F,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] instrD,
    output logic [XLEN-1:0] PCD,
    output logic [XLEN-1:0] PCPlus4D
);

    localparam int PW = 3 * XLEN;

`ifdef IF_ID_NOP_BUBBLE_EN
    localparam bit BUBBLE_EN = 1'b1;
`else
    localparam bit BUBBLE_EN = 1'b0;
`endif

    // Bubble payload: instr field may be NOP, PC fields always clear to 0.
    localparam logic [XLEN-1:0] BUBBLE_INSTR = BUBBLE_EN ? NOP_INSTR : '0;
    localparam logic [PW-1:0]   BUBBLE       = {BUBBLE_INSTR, {(2*XLEN){1'b0}}};

    if_id_state_e  state_q, state_d;
    logic          in_ready_q, in_ready_d;
    logic          accept, issue;
    logic          load_main, load_skid;
    logic [PW-1:0] in_payload, main_d, main_q, skid_q;

    assign accept     = in_valid & in_ready_q;
    assign out_valid  = (state_q != EMPTY);
    assign issue      = out_valid & out_ready;
    assign in_ready   = in_ready_q;
    assign in_payload = {instrF, PCF, PCPlus4F};
    // Main refills from skid when draining SKID, otherwise from fetch.
    assign main_d     = (state_q == SKID) ? skid_q : in_payload;

    // State and registered in_ready.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= EMPTY;
            in_ready_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            in_ready_q <= in_ready_d;
        end
    end

    // Next state and slot load strobes; flush overrides everything.
    always_comb begin
        state_d   = state_q;
        load_main = 1'b0;
        load_skid = 1'b0;
        case (state_q)
            EMPTY: begin
                if (accept) begin
                    load_main = 1'b1;
                    state_d   = FULL;
                end
            end
            FULL: begin
                if (issue && accept) begin
                    load_main = 1'b1;
                end else if (issue) begin
                    state_d   = EMPTY;
                end else if (accept) begin
                    load_skid = 1'b1;
                    state_d   = SKID;
                end
            end
            SKID: begin
                if (issue) begin
                    load_main = 1'b1;
                    state_d   = FULL;
                end
            end
            default: state_d = EMPTY;
        endcase
        if (flush) begin
            state_d   = EMPTY;
            load_main = 1'b0;
            load_skid = 1'b0;
        end
        in_ready_d = (state_d != SKID);
    end

    pipe_payload_slot #(.W(PW), .BUBBLE(BUBBLE)) u_main (
        .clk_i   (clk),
        .rst_ni  (rst),
        .load_i  (load_main),
        .clear_i (flush),
        .d_i     (main_d),
        .q_o     (main_q)
    );

    pipe_payload_slot #(.W(PW), .BUBBLE(BUBBLE)) u_skid (
        .clk_i   (clk),
        .rst_ni  (rst),
        .load_i  (load_skid),
        .clear_i (flush),
        .d_i     (in_payload),
        .q_o     (skid_q)
    );

`ifdef IF_ID_NOP_BUBBLE_EN
    // Legacy decode ignoring out_valid sees a NOP whenever the stage is empty.
    assign instrD = out_valid ? main_q[PW-1 -: XLEN] : NOP_INSTR;
`else
    assign instrD = main_q[PW-1 -: XLEN];
`endif
    assign PCD      = main_q[2*XLEN-1 -: XLEN];
    assign PCPlus4D = main_q[XLEN-1:0];

endmodule

// File: tb/tb_if_id_pipe_stage.sv
// Bench for if_id_pipe_stage: directed scenarios followed by a random
// valid/ready/flush soak, all checked against a queue model of the stage.
module tb_if_id_pipe_stage;
    import riscv_pipe_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic        in_ready, out_valid;
    logic [31:0] instrF = '0, PCF = '0, PCPlus4F = '0;
    logic [31:0] instrD, PCD, PCPlus4D;

    int total = 0;
    int bad   = 0;

    // Model: entries held by the stage, oldest first; shown = payload on outputs.
    if_id_payload_t q[$];
    if_id_payload_t shown;

    always #5 clk = ~clk;

    if_id_pipe_stage u_dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .instrF    (instrF),
        .PCF       (PCF),
        .PCPlus4F  (PCPlus4F),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .instrD    (instrD),
        .PCD       (PCD),
        .PCPlus4D  (PCPlus4D)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] bubble_instr();
`ifdef IF_ID_NOP_BUBBLE_EN
        return NOP_INSTR;
`else
        return 32'h0;
`endif
    endfunction

    function automatic logic [31:0] exp_instr();
`ifdef IF_ID_NOP_BUBBLE_EN
        return (q.size() != 0) ? q[0].instr : NOP_INSTR;
`else
        return shown.instr;
`endif
    endfunction

    task automatic check_model();
        chk("out_valid", 32'(out_valid), 32'(q.size() != 0));
        chk("in_ready",  32'(in_ready),  32'(q.size() != 2));
        chk("instrD",    instrD,   exp_instr());
        chk("PCD",       PCD,      shown.pc);
        chk("PCPlus4D",  PCPlus4D, shown.pc4);
    endtask

    // One clock cycle: drive at negedge, advance model at posedge, check at next negedge.
    task automatic cyc(input logic fl, input logic iv, input logic ordy, input logic [31:0] pc);
        if_id_payload_t p;
        logic acc, iss;
        p.instr = $urandom;
        p.pc    = pc;
        p.pc4   = pc + 32'd4;
        flush = fl; in_valid = iv; out_ready = ordy;
        instrF = p.instr; PCF = p.pc; PCPlus4F = p.pc4;
        #1;
        // in_ready must reflect stored occupancy only, whatever out_ready does now
        chk("in_ready_pre", 32'(in_ready), 32'(q.size() != 2));
        acc = iv && (q.size() != 2);
        iss = ordy && (q.size() != 0);
        @(posedge clk);
        if (fl) begin
            q.delete();
            shown = '0;
        end else begin
            if (iss) void'(q.pop_front());
            if (acc) q.push_back(p);
            if (q.size() != 0) shown = q[0];
        end
        @(negedge clk);
        check_model();
    endtask

    initial begin
        shown = '0;

        // Power-on reset
        repeat (2) @(negedge clk);
        chk("rst_out_valid", 32'(out_valid), 32'h0);
        chk("rst_in_ready",  32'(in_ready),  32'h1);
        chk("rst_instrD",    instrD, bubble_instr());
        chk("rst_PCD",       PCD, 32'h0);
        rst = 1'b1;

        // Streaming: 0x0,0x4,0x8 appear one cycle after acceptance
        cyc(0, 1, 1, 32'h0); chk("stream0", PCD, 32'h0);
        cyc(0, 1, 1, 32'h4); chk("stream1", PCD, 32'h4);
        cyc(0, 1, 1, 32'h8); chk("stream2", PCD, 32'h8);
        cyc(0, 0, 1, 32'h0); chk("stream_drain", 32'(out_valid), 32'h0);

        // Stall fill into SKID, then drain in order
        cyc(0, 1, 0, 32'h10);
        cyc(0, 1, 0, 32'h14);
        chk("skid_in_ready", 32'(in_ready), 32'h0);
        chk("skid_head",     PCD, 32'h10);
        cyc(0, 1, 0, 32'h18);   // offered while full, must not be taken
        cyc(0, 0, 1, 32'h0);  chk("skid_issue2", PCD, 32'h14);
        chk("skid_ready_back", 32'(in_ready), 32'h1);
        cyc(0, 0, 1, 32'h0);  chk("skid_empty", 32'(out_valid), 32'h0);

        // Flush while in SKID with an input offered
        cyc(0, 1, 0, 32'h30);
        cyc(0, 1, 0, 32'h34);
        cyc(1, 1, 0, 32'h20);
        chk("flush_valid", 32'(out_valid), 32'h0);
        chk("flush_ready", 32'(in_ready),  32'h1);
        chk("flush_pc",    PCD, 32'h0);
        cyc(0, 0, 1, 32'h0);  chk("flush_no20", 32'(out_valid), 32'h0);

        // Flush + stall + accept in the same cycle
        cyc(0, 1, 0, 32'h50);
        cyc(1, 1, 0, 32'h54);
        chk("fsa_empty", 32'(out_valid), 32'h0);
        cyc(0, 1, 1, 32'h40); chk("fsa_pc40", PCD, 32'h40);
        cyc(0, 0, 1, 32'h0);  chk("fsa_alone", 32'(out_valid), 32'h0);

        // Async reset mid-stream, checked before any clock edge
        cyc(0, 1, 0, 32'h60);
        cyc(0, 1, 0, 32'h64);
        #2 rst = 1'b0;
        #1;
        chk("mid_rst_valid", 32'(out_valid), 32'h0);
        chk("mid_rst_ready", 32'(in_ready),  32'h1);
        chk("mid_rst_instr", instrD, bubble_instr());
        chk("mid_rst_pc",    PCD, 32'h0);
        q.delete();
        shown = '0;
        @(negedge clk);
        rst = 1'b1;
        cyc(0, 1, 1, 32'h70); chk("post_rst_accept", PCD, 32'h70);

        // Random soak
        for (int i = 0; i < 10000; i++) begin
            cyc(($urandom_range(0, 49) == 0), 1'($urandom), 1'($urandom), $urandom & 32'hFFFF_FFFC);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
